game_ctrl_fsm: RTL and testbench

//  Top-level game sequencer: owns IDLE/PLAY/DYING/OVER state and gates bird/tube motion via run_en.

---
 rtl/game_ctrl_fsm.sv | 165 ++++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_fsm.sv
// ============================================================================
// Module   : game_ctrl_fsm
// Brief    : Game sequencer (IDLE/PLAY/DYING/OVER), tube-pass scoring and
//            session best score; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_ctrl_fsm #(
    parameter int BIRD_X       = 180,
    parameter int BIRD_HALF    = 15,
    parameter int TUBE_HALF    = 30,
    parameter int DEATH_FRAMES = 30,
    parameter int HOLDOFF      = 60,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               frame_tick,
    input  logic               flap,
    input  logic               crash,
    input  logic [9:0]         tube1_x_pos,
    input  logic [9:0]         tube2_x_pos,
    input  logic [9:0]         tube3_x_pos,
    output logic [1:0]         state,
    output logic               run_en,
    output logic               fall_only,
    output logic               flap_pulse,
    output logic               world_rst,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best,
    output logic               game_over
);

    localparam logic [1:0] c_st_idle  = 2'b00;
    localparam logic [1:0] c_st_play  = 2'b01;
    localparam logic [1:0] c_st_dying = 2'b10;
    localparam logic [1:0] c_st_over  = 2'b11;

    localparam int CNT_MAX = (DEATH_FRAMES > HOLDOFF) ? DEATH_FRAMES : HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_death_load   = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_holdoff_load = CNT_W'(HOLDOFF - 1);
    localparam logic [10:0]      c_line         = 11'(BIRD_X - BIRD_HALF);

    logic [1:0]         r_state;
    logic               r_flap_q;
    logic               r_run_en;
    logic               r_fall_only;
    logic               r_flap_pulse;
    logic               r_world_rst;
    logic               r_game_over;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_best;
    logic [CNT_W-1:0]   r_cnt;
    logic [10:0]        r_prev_right [3];

    logic [9:0]         w_x     [3];
    logic [10:0]        w_right [3];
    logic [2:0]         w_pass;
    logic [1:0]         w_pass_cnt;
    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_sat;
    logic [SCORE_W-1:0] w_best_next;
    logic               w_edge;

    assign w_x[0] = tube1_x_pos;
    assign w_x[1] = tube2_x_pos;
    assign w_x[2] = tube3_x_pos;

    // A pass is the tube's right edge moving from at/right of the bird's left
    // edge to strictly left of it; a wrap moves right and can never match.
    generate
        for (genvar i = 0; i < 3; i++) begin : g_tube
            assign w_right[i] = {1'b0, w_x[i]} + 11'(TUBE_HALF);
            assign w_pass[i]  = (r_prev_right[i] >= c_line) && (w_right[i] < c_line);
        end
    endgenerate

    assign w_pass_cnt  = {1'b0, w_pass[0]} + {1'b0, w_pass[1]} + {1'b0, w_pass[2]};
    assign w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(w_pass_cnt);
    assign w_score_sat = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
    assign w_best_next = (r_score > r_best) ? r_score : r_best;
    assign w_edge      = flap & ~r_flap_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= c_st_idle;
            r_flap_q     <= 1'b1;
            r_run_en     <= 1'b0;
            r_fall_only  <= 1'b0;
            r_flap_pulse <= 1'b0;
            r_world_rst  <= 1'b1;
            r_game_over  <= 1'b0;
            r_score      <= '0;
            r_best       <= '0;
            r_cnt        <= '0;
            for (int i = 0; i < 3; i++) r_prev_right[i] <= '0;
        end else begin
            r_flap_q     <= flap;
            r_flap_pulse <= 1'b0;
            r_world_rst  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_edge) begin
                        r_state  <= c_st_play;
                        r_run_en <= 1'b1;
                        r_score  <= '0;
                        for (int i = 0; i < 3; i++) r_prev_right[i] <= w_right[i];
                    end
                end
                c_st_play: begin
                    if (crash) begin
                        r_state     <= c_st_dying;
                        r_run_en    <= 1'b0;
                        r_fall_only <= 1'b1;
                        r_cnt       <= c_death_load;
                    end else begin
                        r_flap_pulse <= w_edge;
                        if (frame_tick) begin
                            r_score <= w_score_sat;
                            for (int i = 0; i < 3; i++) r_prev_right[i] <= w_right[i];
                        end
                    end
                end
                c_st_dying: begin
                    if (frame_tick) begin
                        if (r_cnt == '0) begin
                            r_state     <= c_st_over;
                            r_fall_only <= 1'b0;
                            r_game_over <= 1'b1;
                            r_cnt       <= c_holdoff_load;
                            r_best      <= w_best_next;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                c_st_over: begin
                    // Edges during holdoff are dropped, not remembered.
                    if (w_edge && (r_cnt == '0)) begin
                        r_state     <= c_st_idle;
                        r_game_over <= 1'b0;
                        r_world_rst <= 1'b1;
                    end else if (frame_tick && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign state      = r_state;
    assign run_en     = r_run_en;
    assign fall_only  = r_fall_only;
    assign flap_pulse = r_flap_pulse;
    assign world_rst  = r_world_rst;
    assign score      = r_score;
    assign best       = r_best;
    assign game_over  = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
// ============================================================================
// Module   : tb_game_ctrl_fsm
// Brief    : Directed self-checking bench for game_ctrl_fsm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl_fsm;

    logic       clk = 1'b0;
    logic       clr;
    logic       frame_tick;
    logic       flap;
    logic       crash;
    logic [9:0] tube1_x_pos;
    logic [9:0] tube2_x_pos;
    logic [9:0] tube3_x_pos;
    logic [1:0] state;
    logic       run_en;
    logic       fall_only;
    logic       flap_pulse;
    logic       world_rst;
    logic [7:0] score;
    logic [7:0] best;
    logic       game_over;

    int n_vec = 0;
    int n_err = 0;

    game_ctrl_fsm dut (
        .clk        (clk),
        .clr        (clr),
        .frame_tick (frame_tick),
        .flap       (flap),
        .crash      (crash),
        .tube1_x_pos(tube1_x_pos),
        .tube2_x_pos(tube2_x_pos),
        .tube3_x_pos(tube3_x_pos),
        .state      (state),
        .run_en     (run_en),
        .fall_only  (fall_only),
        .flap_pulse (flap_pulse),
        .world_rst  (world_rst),
        .score      (score),
        .best       (best),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tubes(input int a, input int b, input int c);
        tube1_x_pos = 10'(a);
        tube2_x_pos = 10'(b);
        tube3_x_pos = 10'(c);
    endtask

    initial begin
        clr = 1'b1; flap = 1'b1; frame_tick = 1'b0; crash = 1'b0;
        set_tubes(300, 300, 300);

        // Reset held 2 cycles with flap held high
        step(); step();
        chk("rst_state", 32'(state), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_best", 32'(best), 0);
        chk("rst_run_en", 32'(run_en), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_world_rst", 32'(world_rst), 1);
        clr = 1'b0;
        chk("rel_world_rst_1st", 32'(world_rst), 1);
        step();
        chk("rel_world_rst_2nd", 32'(world_rst), 0);
        step(); step();
        chk("held_flap_no_start", 32'(state), 0);

        // Start a game
        flap = 1'b0; step();
        flap = 1'b1; step();
        chk("start_state", 32'(state), 1);
        chk("start_run_en", 32'(run_en), 1);
        chk("start_score", 32'(score), 0);
        chk("start_no_pulse", 32'(flap_pulse), 0);
        step();
        chk("start_no_pulse2", 32'(flap_pulse), 0);

        // Flap pulse in PLAY
        flap = 1'b0; step();
        flap = 1'b1; step();
        chk("play_pulse", 32'(flap_pulse), 1);
        step();
        chk("play_pulse_end", 32'(flap_pulse), 0);

        // Single pass: right 226,224,166 no pass; 164 passes
        set_tubes(196, 300, 300); tick();
        set_tubes(194, 300, 300); tick();
        set_tubes(136, 300, 300); tick();
        chk("pre_pass_score", 32'(score), 0);
        set_tubes(134, 300, 300); tick();
        chk("single_pass", 32'(score), 1);
        set_tubes(132, 300, 300); tick();
        chk("single_pass_once", 32'(score), 1);

        // Wrap to right does not score; then two tubes cross together
        set_tubes(300, 300, 300); tick();
        chk("wrap_no_score", 32'(score), 1);
        set_tubes(136, 136, 300); tick();
        set_tubes(134, 134, 300); tick();
        chk("double_pass", 32'(score), 3);

        // Crash on a tick with a pass
        set_tubes(300, 300, 300); tick();
        set_tubes(136, 300, 300); tick();
        set_tubes(134, 300, 300);
        crash = 1'b1; tick(); crash = 1'b0;
        chk("crash_score_kept", 32'(score), 3);
        chk("crash_state", 32'(state), 2);
        chk("crash_fall_only", 32'(fall_only), 1);
        chk("crash_run_en", 32'(run_en), 0);

        // Flaps ignored while dying
        flap = 1'b0; step();
        flap = 1'b1; step();
        chk("dying_no_pulse", 32'(flap_pulse), 0);
        chk("dying_flap_state", 32'(state), 2);

        for (int i = 0; i < 29; i++) tick();
        chk("dying_29_ticks", 32'(state), 2);
        tick();
        chk("over_state", 32'(state), 3);
        chk("over_game_over", 32'(game_over), 1);
        chk("over_fall_only", 32'(fall_only), 0);
        chk("over_best", 32'(best), 3);

        // Holdoff: edge at tick 10 ignored and not queued
        for (int i = 0; i < 10; i++) tick();
        flap = 1'b0; step();
        flap = 1'b1; step();
        chk("holdoff_edge_ignored", 32'(state), 3);
        for (int i = 0; i < 50; i++) tick();
        chk("holdoff_not_queued", 32'(state), 3);
        flap = 1'b0; step();
        flap = 1'b1; step();
        chk("restart_state", 32'(state), 0);
        chk("restart_world_rst", 32'(world_rst), 1);
        chk("restart_game_over", 32'(game_over), 0);
        chk("restart_best", 32'(best), 3);
        step();
        chk("restart_world_rst_end", 32'(world_rst), 0);

        // Start edge coincident with a tick and a would-be pass
        set_tubes(134, 300, 300);
        flap = 1'b0; step();
        flap = 1'b1; frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("g2_state", 32'(state), 1);
        chk("g2_start_tick_no_score", 32'(score), 0);
        chk("g2_best_kept", 32'(best), 3);
        tick();
        chk("g2_prev_init", 32'(score), 0);

        // Saturation: 85 rounds of three passes reach 255
        for (int i = 0; i < 85; i++) begin
            set_tubes(300, 300, 300); tick();
            set_tubes(134, 134, 134); tick();
        end
        chk("sat_reach_255", 32'(score), 255);
        set_tubes(300, 134, 134); tick();
        set_tubes(134, 134, 134); tick();
        chk("sat_hold_255", 32'(score), 255);
        chk("sat_state_play", 32'(state), 1);

        // Mid-game reset clears everything including best
        clr = 1'b1; step();
        chk("clr2_state", 32'(state), 0);
        chk("clr2_score", 32'(score), 0);
        chk("clr2_best", 32'(best), 0);
        chk("clr2_run_en", 32'(run_en), 0);
        chk("clr2_world_rst", 32'(world_rst), 1);
        clr = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
